// File: rtl/mm_arbiter.sv
// Two-port round-robin arbiter and sequencer for the 256-bit-line main memory.
// Grants one L1 requester at a time and drives the memory address/strobe protocol.
module mm_arbiter #(
    parameter int ADDR_W      = 27,
    parameter int MEM_ENTRIES = 256,
    parameter int TIMEOUT     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [31:0]       r0_be,
    input  logic [255:0]      r0_wd,
    output logic              r0_ack,
    output logic              r0_err,
    output logic [255:0]      r0_rd,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [31:0]       r1_be,
    input  logic [255:0]      r1_wd,
    output logic              r1_ack,
    output logic              r1_err,
    output logic [255:0]      r1_rd,
    output logic [ADDR_W-1:0] mm_a,
    output logic [31:0]       mm_be,
    output logic [255:0]      mm_wd,
    output logic              mm_read,
    output logic              mm_write,
    input  logic [255:0]      mm_rd,
    input  logic              mm_valid,
    input  logic              mm_ready,
    output logic              busy,
    output logic              gnt_id
);

    localparam int                CNT_W      = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_ENTRIES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t            state;
    logic              last_gnt;
    logic              txn_we;
    logic [CNT_W-1:0]  wait_cnt;

    logic              any_req;
    logic              winner;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_be;
    logic [255:0]      sel_wd;
    logic              out_of_range;
    logic              resp_fire;
    logic              resp_err;
    logic              resp_port;
    logic [255:0]      resp_data;

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        any_req      = r0_req | r1_req;
        winner       = (r0_req && r1_req) ? ~last_gnt : r1_req;
        sel_we       = winner ? r1_we   : r0_we;
        sel_addr     = winner ? r1_addr : r0_addr;
        sel_be       = winner ? r1_be   : r0_be;
        sel_wd       = winner ? r1_wd   : r0_wd;
        out_of_range = (sel_addr >= ADDR_LIMIT);
        resp_fire    = 1'b0;
        resp_err     = 1'b0;
        resp_port    = gnt_id;
        resp_data    = '0;
        case (state)
            ST_IDLE: begin
                if (any_req && out_of_range) begin
                    resp_fire = 1'b1;
                    resp_err  = 1'b1;
                    resp_port = winner;
                end
            end
            ST_WAIT: begin
                // A response of the wrong type for this transaction is ignored.
                if (!txn_we && mm_valid) begin
                    resp_fire = 1'b1;
                    resp_data = mm_rd;
                end else if (txn_we && mm_ready) begin
                    resp_fire = 1'b1;
                end else if (wait_cnt == CNT_LAST) begin
                    resp_fire = 1'b1;
                    resp_err  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign busy = (state != ST_IDLE);

    // NOTE: all state uses non-blocking assignments; reset is synchronous to clk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            last_gnt <= 1'b1;
            gnt_id   <= 1'b0;
            txn_we   <= 1'b0;
            wait_cnt <= '0;
            mm_a     <= '0;
            mm_be    <= '0;
            mm_wd    <= '0;
            mm_read  <= 1'b0;
            mm_write <= 1'b0;
            r0_ack   <= 1'b0;
            r0_err   <= 1'b0;
            r0_rd    <= '0;
            r1_ack   <= 1'b0;
            r1_err   <= 1'b0;
            r1_rd    <= '0;
        end else begin
            r0_ack   <= 1'b0;
            r0_err   <= 1'b0;
            r1_ack   <= 1'b0;
            r1_err   <= 1'b0;
            mm_read  <= 1'b0;
            mm_write <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        gnt_id   <= winner;
                        last_gnt <= winner;
                        txn_we   <= sel_we;
                        if (!out_of_range) begin
                            mm_a  <= sel_addr;
                            mm_be <= sel_be;
                            mm_wd <= sel_wd;
                            state <= ST_SETUP;
                        end
                    end
                end
                // Address is already stable here; memory latches it before the strobe.
                ST_SETUP: begin
                    mm_read  <= ~txn_we;
                    mm_write <= txn_we;
                    state    <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
            if (resp_fire) begin
                state <= ST_RESP;
                if (resp_port) begin
                    r1_ack <= 1'b1;
                    r1_err <= resp_err;
                    r1_rd  <= resp_data;
                end else begin
                    r0_ack <= 1'b1;
                    r0_err <= resp_err;
                    r0_rd  <= resp_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_mm_arbiter.sv
// Directed bench for mm_arbiter with a two-cycle-latency line memory model.
// Checks latencies, strobe timing, arbitration order, errors and reset behaviour.
module tb_mm_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         r0_req, r0_we, r1_req, r1_we;
    logic [26:0]  r0_addr, r1_addr;
    logic [31:0]  r0_be, r1_be;
    logic [255:0] r0_wd, r1_wd;
    logic         r0_ack, r0_err, r1_ack, r1_err;
    logic [255:0] r0_rd, r1_rd;
    logic [26:0]  mm_a;
    logic [31:0]  mm_be;
    logic [255:0] mm_wd, mm_rd;
    logic         mm_read, mm_write, mm_valid, mm_ready;
    logic         busy, gnt_id;

    int n_checks = 0;
    int n_fail   = 0;

    mm_arbiter #(.ADDR_W(27), .MEM_ENTRIES(256), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_be(r0_be), .r0_wd(r0_wd),
        .r0_ack(r0_ack), .r0_err(r0_err), .r0_rd(r0_rd),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_be(r1_be), .r1_wd(r1_wd),
        .r1_ack(r1_ack), .r1_err(r1_err), .r1_rd(r1_rd),
        .mm_a(mm_a), .mm_be(mm_be), .mm_wd(mm_wd), .mm_read(mm_read), .mm_write(mm_write),
        .mm_rd(mm_rd), .mm_valid(mm_valid), .mm_ready(mm_ready),
        .busy(busy), .gnt_id(gnt_id)
    );

    always #5 clk = ~clk;

    // Memory model: response two cycles after the strobe cycle; stall suppresses it.
    logic [255:0] mem [256];
    logic         rd_p1 = 1'b0, rd_p2 = 1'b0, wr_p1 = 1'b0, wr_p2 = 1'b0;
    logic [7:0]   rd_addr = '0;
    logic         stall = 1'b0;

    always @(posedge clk) begin
        rd_p1 <= mm_read;
        rd_p2 <= rd_p1;
        wr_p1 <= mm_write;
        wr_p2 <= wr_p1;
        if (mm_read)  rd_addr <= mm_a[7:0];
        if (mm_write) mem[mm_a[7:0]] <= mm_wd;
    end

    assign mm_valid = rd_p2 && !stall;
    assign mm_ready = wr_p2 && !stall;
    assign mm_rd    = rd_p2 ? mem[rd_addr] : '0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit port, input bit v);
        if (port) r1_req = v; else r0_req = v;
    endtask

    // One transaction: request goes up in an IDLE cycle T; latency counted from T.
    task automatic run_txn(input string tag, input bit port, input bit we,
                           input logic [26:0] addr, input logic [255:0] wd,
                           input int exp_lat, input bit exp_err,
                           input logic [255:0] exp_rd, input bit drop_early);
        int   lat = 0, rd_k = 0, wr_k = 0, n_strb = 0;
        bit   got = 0, other = 0, err = 0;
        logic [255:0] rd = '0;
        step();
        if (port) begin r1_we = we; r1_addr = addr; r1_wd = wd; r1_be = '1; end
        else      begin r0_we = we; r0_addr = addr; r0_wd = wd; r0_be = '1; end
        set_req(port, 1'b1);
        for (int k = 1; k <= 40 && !got; k++) begin
            step();
            if (k == 1) begin
                check({tag, " gnt_id"}, 256'(gnt_id), 256'(port));
                if (addr < 256) check({tag, " mm_a setup"}, 256'(mm_a), 256'(addr));
                if (drop_early) set_req(port, 1'b0);
            end
            if (k == exp_lat - 1 && addr < 256)
                check({tag, " mm_a held"}, 256'(mm_a), 256'(addr));
            if (mm_read)  begin rd_k = k; n_strb++; end
            if (mm_write) begin wr_k = k; n_strb++; end
            if (port ? r0_ack : r1_ack) other = 1;
            if (port ? r1_ack : r0_ack) begin
                got = 1;
                lat = k;
                err = port ? r1_err : r0_err;
                rd  = port ? r1_rd : r0_rd;
                set_req(port, 1'b0);
            end
        end
        check({tag, " ack latency"}, 256'(lat), 256'(exp_lat));
        check({tag, " err"}, 256'(err), 256'(exp_err));
        check({tag, " rd"}, rd, exp_rd);
        check({tag, " strobe count"}, 256'(n_strb), (addr < 256) ? 256'd1 : 256'd0);
        check({tag, " read strobe cycle"}, 256'(rd_k), (addr < 256 && !we) ? 256'd2 : 256'd0);
        check({tag, " write strobe cycle"}, 256'(wr_k), (addr < 256 && we) ? 256'd2 : 256'd0);
        check({tag, " other ack"}, 256'(other), 256'd0);
    endtask

    // Both ports raise req together; port 0 must win, then port 1 right after.
    task automatic tie_round(input string tag);
        int a0 = 0, a1 = 0;
        step();
        r0_we = 1'b1; r0_addr = 27'd10; r0_wd = {32{8'h3C}}; r0_be = '1;
        r1_we = 1'b0; r1_addr = 27'd5;  r1_be = '1;
        r0_req = 1'b1; r1_req = 1'b1;
        for (int k = 1; k <= 40 && (a0 == 0 || a1 == 0); k++) begin
            step();
            if (k == 1) check({tag, " first gnt"}, 256'(gnt_id), 256'd0);
            if (k == 7) check({tag, " second gnt"}, 256'(gnt_id), 256'd1);
            if (r0_ack) begin a0 = k; r0_req = 1'b0; end
            if (r1_ack) begin
                a1 = k; r1_req = 1'b0;
                check({tag, " port1 rd"}, r1_rd, {32{8'hA5}});
            end
        end
        check({tag, " port0 ack cycle"}, 256'(a0), 256'd5);
        check({tag, " port1 ack cycle"}, 256'(a1), 256'd11);
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        rst_n = 1'b0;
        r0_req = 0; r0_we = 0; r0_addr = '0; r0_be = '0; r0_wd = '0;
        r1_req = 0; r1_we = 0; r1_addr = '0; r1_be = '0; r1_wd = '0;
        repeat (3) step();
        check("reset busy", 256'(busy), 256'd0);
        check("reset gnt_id", 256'(gnt_id), 256'd0);
        check("reset mm_a", 256'(mm_a), 256'd0);
        check("reset strobes", 256'({mm_read, mm_write}), 256'd0);
        check("reset acks", 256'({r0_ack, r1_ack, r0_err, r1_err}), 256'd0);
        rst_n = 1'b1;

        run_txn("p0 write a5", 1'b0, 1'b1, 27'd5, {32{8'hA5}}, 5, 1'b0, '0, 1'b0);
        run_txn("p1 read a5",  1'b1, 1'b0, 27'd5, '0, 5, 1'b0, {32{8'hA5}}, 1'b0);
        run_txn("p1 read a300", 1'b1, 1'b0, 27'd300, '0, 1, 1'b1, '0, 1'b0);
        check("p0 rd held", r0_rd, '0);

        stall = 1'b1;
        run_txn("p0 timeout", 1'b0, 1'b0, 27'd5, '0, 11, 1'b1, '0, 1'b0);
        stall = 1'b0;
        run_txn("p1 after timeout", 1'b1, 1'b0, 27'd5, '0, 5, 1'b0, {32{8'hA5}}, 1'b0);

        run_txn("p0 early drop", 1'b0, 1'b1, 27'd9, {32{8'h5A}}, 5, 1'b0, '0, 1'b1);
        run_txn("p0 read a9", 1'b0, 1'b0, 27'd9, '0, 5, 1'b0, {32{8'h5A}}, 1'b0);

        // Reset while in WAIT: no ack, outputs back to reset values, later valid ignored.
        step();
        r0_we = 1'b0; r0_addr = 27'd5; r0_req = 1'b1;
        repeat (3) step();
        check("pre-reset busy", 256'(busy), 256'd1);
        rst_n = 1'b0; r0_req = 1'b0;
        step();
        check("midrst busy", 256'(busy), 256'd0);
        check("midrst acks", 256'({r0_ack, r1_ack}), 256'd0);
        check("midrst mm_a", 256'(mm_a), 256'd0);
        check("midrst r1_rd", r1_rd, '0);
        check("midrst r0_rd", r0_rd, '0);
        rst_n = 1'b1;
        seen = 0;
        repeat (4) begin
            step();
            if (r0_ack || r1_ack || busy) seen = 1;
        end
        check("post-reset quiet", 256'(seen), 256'd0);

        tie_round("tie round 1");
        tie_round("tie round 2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mm_arbiter.md
# mm_arbiter

Two-port arbiter and sequencer for the 256-bit-line main memory model. Port 0 (D-cache fill/writeback) and port 1 (I-cache fill) share the memory through round-robin arbitration. For each granted transaction the block drives the memory's address/strobe protocol, waits on `valid`/`ready` with a timeout, and returns data or a completion pulse to the winner. It sits between the L1 controllers and `mainmemory`, and owns all memory strobes.

## Interface
- `ADDR_W`, 27: line-address width.
- `MEM_ENTRIES`, 256: valid line addresses are 0..MEM_ENTRIES-1.
- `TIMEOUT`, 8: WAIT cycles allowed before an error response.
- `clk` in 1: clock, all logic on posedge.
- `rst_n` in 1: reset, synchronous, active-low.
- `r0_req`, `r1_req` in 1: request, held high until the matching ack.
- `r0_we`, `r1_we` in 1: 1 means write, 0 means read.
- `r0_addr`, `r1_addr` in ADDR_W: line address.
- `r0_be`, `r1_be` in 32: byte enables, forwarded only.
- `r0_wd`, `r1_wd` in 256: write data.
- `r0_ack`, `r1_ack` out 1: one-cycle completion pulse.
- `r0_err`, `r1_err` out 1: qualifies ack; out-of-range address or timeout.
- `r0_rd`, `r1_rd` out 256: read data, valid with ack on a read.
- `mm_a` out ADDR_W: memory address.
- `mm_be` out 32: memory byte enables.
- `mm_wd` out 256: memory write data.
- `mm_read`, `mm_write` out 1: memory strobes, exactly one cycle each.
- `mm_rd` in 256, `mm_valid` in 1, `mm_ready` in 1: memory read data, read complete, write complete.
- `busy` out 1: state is not IDLE.
- `gnt_id` out 1: current owner, meaningful while busy.

## Operation
- FSM states: IDLE, SETUP, ISSUE, WAIT, RESP.
- IDLE, no req: stay in IDLE.
- IDLE, any req:
  - Pick the owner and set `gnt_id`.
  - Register that port's we/addr/be/wd into a transaction register.
  - If addr >= MEM_ENTRIES, go to RESP with err=1 and no memory access.
  - Otherwise go to SETUP.
- Arbitration:
  - Only one request: that port wins.
  - Both requesting: the port not granted last wins.
  - The last-grant pointer updates on every grant and resets to 1, so port 0 wins the first tie.
- SETUP: drive `mm_a`/`mm_be`/`mm_wd` from the transaction register with strobes low. Memory latches its write address one cycle early, so the address must be stable the cycle before the strobe.
- ISSUE: assert `mm_read` or `mm_write` for exactly this cycle, then go to WAIT.
- `mm_a`/`mm_be`/`mm_wd` are held constant from SETUP through the end of WAIT.
- WAIT, with a counter cleared on entry:
  - For a read, `mm_valid` high means capture `mm_rd` and go to RESP, err=0.
  - For a write, `mm_ready` high means go to RESP, err=0.
  - The counter reaching TIMEOUT without the expected response means RESP with err=1 and read data zero.
  - The wrong-type response (for example `mm_ready` during a read) is ignored.
- RESP:
  - Pulse the owner's ack with err.
  - Drive its rd with the captured data (zero on writes and errors).
  - Go to IDLE.
  - The non-owner's ack/err stay 0.
- Deassertion of req after grant is ignored; the transaction completes and ack still pulses.
- The requester drops req the cycle after ack. IDLE never re-grants in the same cycle as RESP.
- `rN_rd` holds its last value until the next ack to that port.

## Timing
- Reset values: all acks, errs, strobes and `busy` are 0; `gnt_id` is 0; `mm_a`/`mm_be`/`mm_wd` and `rN_rd` are 0; state is IDLE; last-grant pointer is 1.
- Reset mid-transaction returns to IDLE next cycle with no ack. A strobe in flight is abandoned, and a later `mm_valid`/`mm_ready` seen in IDLE is ignored.
- Read, with req first seen in IDLE at cycle T:
  - T+1 SETUP.
  - T+2 ISSUE (`mm_read`=1).
  - `mm_valid` high in T+4.
  - T+5 RESP (ack plus data).
- Write: same schedule, `mm_ready` in T+4, ack in T+5.
- Out-of-range address: ack with err=1 at T+1.
- Throughput is one transaction per 6 cycles. Alternating ports give back-to-back grants at T, T+6, T+12.
- Timeout: with `mm_valid` never asserted, err ack at T+3+TIMEOUT.

## Test plan
- Port 0 writes addr 5 with wd=0xA5 repeated and be all ones; port 1 then reads addr 5 -> `mm_write` a single pulse at T+2 with `mm_a`=5 from T+1; port 1 ack at T+5 with rd=0xA5 pattern and err=0.
- Both ports request in the same cycle, repeatedly, 4 times -> grants alternate 0,1,0,1; each ack lands exactly 5 cycles after its grant cycle.
- Port 1 reads addr 300 with MEM_ENTRIES=256 -> no `mm_read`; r1_ack=1 and r1_err=1 one cycle after req.
- Memory model stubbed so `mm_valid` is never asserted, TIMEOUT=8 -> err ack at T+11 with rd=0, then the block returns to IDLE and serves the next request normally.
- Assert `rst_n`=0 during WAIT, release after 1 cycle -> outputs at reset values, no ack; the next request uses port-0 priority.
- Port 0 drops req one cycle after grant -> transaction still completes and r0_ack pulses at T+5.
